// File: rtl/seq_det_pkg.sv
// Shared helpers for the serial pattern detector: width/border functions and legal ranges.
package seq_det_pkg;

  localparam int unsigned N_MIN     = 2;
  localparam int unsigned N_MAX     = 16;
  localparam int unsigned CNT_W_MIN = 1;
  localparam int unsigned CNT_W_MAX = 16;

  function automatic int unsigned sw_f(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Longest proper prefix of the pattern that is also a suffix; pattern[n-1] is the first bit.
  function automatic int unsigned border_f(input logic [15:0] pattern, input int unsigned n);
    int unsigned best;
    bit          ok;
    best = 0;
    for (int unsigned l = 1; l < n; l++) begin
      ok = 1'b1;
      for (int unsigned i = 0; i < l; i++) begin
        if (pattern[n-1-i] != pattern[l-1-i]) ok = 1'b0;
      end
      if (ok) best = l;
    end
    return best;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         Re,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;

  always_comb begin
    q_d = q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q_d = q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge Re) begin
    if (!Re) q <= '0;
    else     q <= q_d;
  end

endmodule

// File: rtl/seq_detector.sv
// Parametrised serial pattern recogniser: tracks the longest matched prefix and pulses z per match.
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1011,
  parameter bit          OVERLAP = 1'b1,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned SW     = sw_f(N)
) (
  input  logic             clk,
  input  logic             Re,
  input  logic             en,
  input  logic             w,
  input  logic             clr,
  output logic             z,
  output logic [SW-1:0]    state,
  output logic [CNT_W-1:0] count
);

  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("seq_detector: N must be in 2..16");
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("seq_detector: CNT_W must be in 1..16");
  end

  localparam int unsigned     BORDER = border_f(16'(PATTERN), N);
  localparam logic [SW-1:0]   FULL   = SW'(N);

  // Next matched-prefix length: the string is the first `base` pattern bits followed by b.
  function automatic logic [SW-1:0] nxt_f(input logic [SW-1:0] s, input logic b);
    int unsigned base;
    int unsigned best;
    int unsigned j;
    logic        bit_j;
    logic        ok;
    if (int'(s) >= int'(N)) base = OVERLAP ? BORDER : 0;
    else                    base = int'(s);
    best = 0;
    for (int unsigned l = 1; l <= N; l++) begin
      if (l <= base + 1) begin
        ok = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
          if (i < l) begin
            j     = base + 1 - l + i;
            bit_j = (j == base) ? b : PATTERN[N-1-j];
            if (bit_j != PATTERN[N-1-i]) ok = 1'b0;
          end
        end
        if (ok) best = l;
      end
    end
    return SW'(best);
  endfunction

  logic [SW-1:0] state_d;
  logic          z_d;
  logic          hit;

  always_comb begin
    state_d = state;
    z_d     = 1'b0;
    hit     = 1'b0;
    if (clr) begin
      state_d = '0;
    end else if (en) begin
      state_d = nxt_f(state, w);
      hit     = (state_d == FULL);
      z_d     = hit;
    end
  end

  always_ff @(posedge clk or negedge Re) begin
    if (!Re) begin
      state <= '0;
      z     <= 1'b0;
    end else begin
      state <= state_d;
      z     <= z_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_count (
    .clk(clk),
    .Re (Re),
    .clr(clr),
    .inc(hit),
    .q  (count)
  );

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench: five detector configurations against a stream-history reference model.
module tb_seq_detector;

  logic clk = 1'b0;
  logic re, en, w, clr;
  always #5 clk = ~clk;

  logic [2:0] st0, st1, st2, st3;
  logic [1:0] st4;
  logic       z0, z1, z2, z3, z4;
  logic [7:0] c0, c1;
  logic [1:0] c2;
  logic [2:0] c3;
  logic [3:0] c4;

  seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) d0 (
    .clk(clk), .Re(re), .en(en), .w(w), .clr(clr), .z(z0), .state(st0), .count(c0));
  seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) d1 (
    .clk(clk), .Re(re), .en(en), .w(w), .clr(clr), .z(z1), .state(st1), .count(c1));
  seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) d2 (
    .clk(clk), .Re(re), .en(en), .w(w), .clr(clr), .z(z2), .state(st2), .count(c2));
  seq_detector #(.N(6), .PATTERN(6'b110110), .OVERLAP(1'b1), .CNT_W(3)) d3 (
    .clk(clk), .Re(re), .en(en), .w(w), .clr(clr), .z(z3), .state(st3), .count(c3));
  seq_detector #(.N(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(4)) d4 (
    .clk(clk), .Re(re), .en(en), .w(w), .clr(clr), .z(z4), .state(st4), .count(c4));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: state = longest suffix of the received stream that is a pattern prefix.
  int        mn[5];
  bit [15:0] mp[5];
  bit        mo[5];
  int        mcw[5];
  bit        hist[5][16];
  int        hlen[5];
  int        mst[5];
  bit        mz[5];
  int        mcnt[5];

  typedef struct {
    bit w;
    int st0;
    bit z0;
    int st1;
    bit z1;
  } vec_t;
  vec_t tv[7];

  function automatic int dut_state(int k);
    case (k)
      0: return int'(st0);
      1: return int'(st1);
      2: return int'(st2);
      3: return int'(st3);
      default: return int'(st4);
    endcase
  endfunction

  function automatic int dut_z(int k);
    case (k)
      0: return int'(z0);
      1: return int'(z1);
      2: return int'(z2);
      3: return int'(z3);
      default: return int'(z4);
    endcase
  endfunction

  function automatic int dut_cnt(int k);
    case (k)
      0: return int'(c0);
      1: return int'(c1);
      2: return int'(c2);
      3: return int'(c3);
      default: return int'(c4);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic int longest(int k);
    int best;
    bit ok;
    best = 0;
    for (int l = 1; l <= mn[k]; l++) begin
      if (l <= hlen[k]) begin
        ok = 1'b1;
        for (int i = 0; i < l; i++) begin
          if (hist[k][hlen[k]-l+i] != mp[k][mn[k]-1-i]) ok = 1'b0;
        end
        if (ok) best = l;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 5; k++) begin
      hlen[k] = 0; mst[k] = 0; mz[k] = 1'b0; mcnt[k] = 0;
    end
  endtask

  task automatic model_step(input bit e, input bit b, input bit c);
    for (int k = 0; k < 5; k++) begin
      if (c) begin
        hlen[k] = 0; mst[k] = 0; mz[k] = 1'b0; mcnt[k] = 0;
      end else if (!e) begin
        mz[k] = 1'b0;
      end else begin
        if (hlen[k] == 16) begin
          for (int i = 0; i < 15; i++) hist[k][i] = hist[k][i+1];
          hlen[k] = 15;
        end
        hist[k][hlen[k]] = b;
        hlen[k]++;
        mst[k] = longest(k);
        mz[k]  = (mst[k] == mn[k]);
        if (mz[k]) begin
          if (mcnt[k] < (1 << mcw[k]) - 1) mcnt[k]++;
          if (!mo[k]) hlen[k] = 0;  // matched bits are consumed
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("%s d%0d state", tag, k), dut_state(k), mst[k]);
      check($sformatf("%s d%0d z", tag, k), dut_z(k), int'(mz[k]));
      check($sformatf("%s d%0d count", tag, k), dut_cnt(k), mcnt[k]);
    end
  endtask

  task automatic step(input bit e, input bit b, input bit c, input string tag);
    en = e; w = b; clr = c;
    @(posedge clk);
    #1;
    model_step(e, b, c);
    check_all(tag);
  endtask

  initial begin
    int zc;
    int hold;
    int sat_exp[5];
    bit sat_bits[16];
    int m;

    mn  = '{4, 4, 4, 6, 2};
    mp  = '{16'b1011, 16'b1011, 16'b1011, 16'b110110, 16'b11};
    mo  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    mcw = '{8, 8, 2, 3, 4};
    tv[0] = '{1'b1, 1, 1'b0, 1, 1'b0};
    tv[1] = '{1'b0, 2, 1'b0, 2, 1'b0};
    tv[2] = '{1'b1, 3, 1'b0, 3, 1'b0};
    tv[3] = '{1'b1, 4, 1'b1, 4, 1'b1};
    tv[4] = '{1'b0, 2, 1'b0, 0, 1'b0};
    tv[5] = '{1'b1, 3, 1'b0, 1, 1'b0};
    tv[6] = '{1'b1, 4, 1'b1, 1, 1'b0};
    sat_exp  = '{1, 2, 3, 3, 3};
    sat_bits = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};

    re = 1'b0; en = 1'b0; w = 1'b0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    re = 1'b1;
    step(0, 0, 0, "idle");
    step(1, 0, 0, "idle0");

    // Overlap / non-overlap vectors on the same stimulus
    step(0, 0, 1, "clr");
    for (int i = 0; i < 7; i++) begin
      step(1, tv[i].w, 0, "vec");
      check($sformatf("vec%0d ovl state", i), int'(st0), tv[i].st0);
      check($sformatf("vec%0d ovl z", i), int'(z0), int'(tv[i].z0));
      check($sformatf("vec%0d novl state", i), int'(st1), tv[i].st1);
      check($sformatf("vec%0d novl z", i), int'(z1), int'(tv[i].z1));
    end
    check("ovl final count", int'(c0), 2);
    check("novl final count", int'(c1), 1);

    // Enable gaps between pattern bits
    step(0, 0, 1, "clr");
    zc = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, (i == 1) ? 1'b0 : 1'b1, 0, "gap bit");
      zc += int'(z0);
      hold = int'(st0);
      for (int g = 0; g < 3; g++) begin
        step(0, 1'b1, 0, "gap idle");
        zc += int'(z0);
        check("gap hold state", int'(st0), hold);
      end
    end
    check("gap z pulses", zc, 1);
    check("gap count", int'(c0), 1);

    // Saturation on the 2-bit counter
    step(0, 0, 1, "clr");
    m = 0;
    zc = 0;
    for (int i = 0; i < 16; i++) begin
      step(1, sat_bits[i], 0, "sat");
      zc += int'(z2);
      if (i % 3 == 0 && i > 0) begin
        check($sformatf("sat count match%0d", m), int'(c2), sat_exp[m]);
        m++;
      end
    end
    check("sat z pulses", zc, 5);

    // Asynchronous reset mid-match (d0 holds a partial match and nonzero count)
    step(1, 1, 0, "pre-rst");
    step(1, 0, 0, "pre-rst");
    step(1, 1, 0, "pre-rst");
    #2 re = 1'b0;
    #1;
    model_reset();
    check_all("async rst");
    @(posedge clk);
    #1;
    check_all("rst held");
    re = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1, (i == 0) ? 1'b0 : 1'b1, 0, "post-rst");
      check("post-rst no z", int'(z0), 0);
    end

    // clr on the final pattern bit wins over the sampled bit
    step(0, 0, 1, "clr");
    step(1, 1, 0, "clrp");
    step(1, 0, 0, "clrp");
    step(1, 1, 0, "clrp");
    step(1, 1, 1, "clrp last");
    check("clr-last state", int'(st0), 0);
    check("clr-last z", int'(z0), 0);
    check("clr-last count", int'(c0), 0);
    step(0, 0, 0, "clrp after");
    check("clr-last z after", int'(z0), 0);

    // Pattern 11 with overlap: input 1,1,1 gives two consecutive z cycles
    step(0, 0, 1, "clr");
    step(1, 1, 0, "p11");
    check("p11 s1", int'(st4), 1);
    check("p11 z1", int'(z4), 0);
    step(1, 1, 0, "p11");
    check("p11 z2", int'(z4), 1);
    step(1, 1, 0, "p11");
    check("p11 z3", int'(z4), 1);
    check("p11 count", int'(c4), 2);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_detector.md
# seq_detector

Parametrised serial bit-pattern detector: the generalised successor of the team's fixed-pattern three-state-bit sequence FSM. It samples one serial bit per enabled clock, tracks the longest matched prefix of a configurable pattern, and pulses `z` on each match. It also keeps a saturating match count. It sits on serial input lines as a reusable recogniser, replacing per-pattern hand-coded FSMs.

## Interface
- `N`, 4: pattern length in bits, legal 2..16.
- `PATTERN`, 4'b1011: `N`-bit pattern; `PATTERN[N-1]` is the first bit received.
- `OVERLAP`, 1: 1 = overlapping matches allowed; 0 = matched bits are consumed.
- `CNT_W`, 8: match counter width, legal 1..16.
- `SW`: derived, `$clog2(N+1)`, not overridable.

- `clk`  in  1  rising-edge clock.
- `Re`  in  1  asynchronous, active-low reset.
- `en`  in  1  bit-valid; `w` is sampled only when high.
- `w`  in  1  serial data bit.
- `clr`  in  1  synchronous clear of state, `z` and `count`.
- `z`  out  1  registered one-cycle match pulse.
- `state`  out  `SW`  current matched-prefix length, 0..N.
- `count`  out  `CNT_W`  saturating number of matches.

## Operation
- Reset (`Re`=0, asynchronous): `state`=0, `z`=0, `count`=0, held until `Re` returns high.
- Each rising edge, in priority order:
  - `clr`=1: `state`, `z` and `count` are cleared to 0.
  - `en`=0: `state` and `count` hold; `z`=0.
  - `en`=1: `state` takes the next value `nxt(state, w)`.
- `nxt(s, w)` is the length of the longest prefix of `PATTERN` that is a suffix of (the matched `s` bits followed by `w`), using KMP/failure semantics.
- Leaving a match:
  - When `s`=N and `OVERLAP`=1, the next bit is evaluated from the longest proper border of `PATTERN`.
  - When `s`=N and `OVERLAP`=0, the next bit is evaluated from `s`=0.
- `z` is 1 for the cycle after an edge on which `state` became N. Consecutive matches give consecutive `z` cycles; for example `PATTERN`=2'b11 with `OVERLAP`=1 and input 1,1,1 gives `z` high for 2 cycles.
- `count` increments on the same edge `state` becomes N and saturates at 2^CNT_W−1 (no wrap).
- `nxt` is computed combinationally from parameters (elaboration-time loops/functions); no stored tables.
- Illegal `N` or `CNT_W`: elaboration error.

## Timing
- Latency: `z` and `count` update on the edge that samples the final pattern bit and are visible during the following cycle.
- One bit per cycle at full rate; `en` may be deasserted arbitrarily. Gaps do not break a partial match.
- `clr` together with `en`=1: `clr` wins and the sampled bit is discarded.
- `Re` asserted mid-match: all outputs clear immediately; the partial match is lost.
- Count at max plus a new match: `count` stays at max; `z` still pulses.

## Structure
- Package `seq_det_pkg`:
  - `sw_f(N)` width function.
  - `border_f(PATTERN, N)` elaboration function.
  - Legal-range constants for `N` and `CNT_W`.
- Sub-module `sat_counter` (params `W`; inputs `clk`, `Re`, `clr`, `inc`; output `q`) holds `count`.
- Next-state logic and the state register stay in `seq_detector`.

## Test plan
1. Reset: with `Re`=0 mid-stream, `state`=0, `z`=0 and `count`=0 immediately. After release, no `z` until a full pattern arrives.
2. Overlap match (`PATTERN`=1011, `OVERLAP`=1):
   - Stimulus: w=1,0,1,1,0,1,1 with `en`=1.
   - Required `state` sequence: 1,2,3,4,2,3,4.
   - `z` pulses after bit 4 and after bit 7; final `count`=2.
3. Non-overlap match (`OVERLAP`=0), same stimulus:
   - Required `state` sequence: 1,2,3,4,0,1,1.
   - One `z` pulse; final `count`=1.
4. Enable gaps: 1011 sent with `en`=0 for 3 cycles between each bit. `state` holds during the gaps; exactly one `z` pulse; `count`=1.
5. Saturation (`CNT_W`=2): 5 back-to-back matches give `count` 1,2,3,3,3 and 5 `z` pulses.
6. `clr` priority: assert `clr` with `en`=1 on the final pattern bit. Required: `state`=0, no `z` pulse, `count`=0.
